// File: rtl/upower_lsu_pkg.sv
// Shared types and helpers for the uPOWER load/store unit.
// Op encodings, FSM states, and size/alignment/extension helpers.
package upower_lsu_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned MEM_WORDS = 128;
    localparam int unsigned IDX_W     = 7;

    typedef enum logic [3:0] {
        OP_LD  = 4'h0,
        OP_LWZ = 4'h1,
        OP_LWA = 4'h2,
        OP_LHZ = 4'h3,
        OP_LHA = 4'h4,
        OP_LBZ = 4'h5,
        OP_STD = 4'h8,
        OP_STW = 4'h9,
        OP_STH = 4'hA,
        OP_STB = 4'hB
    } lsu_op_e;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_e;

    function automatic logic opLegal(logic [3:0] op);
        case (op)
            OP_LD, OP_LWZ, OP_LWA, OP_LHZ, OP_LHA, OP_LBZ,
            OP_STD, OP_STW, OP_STH, OP_STB: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic opIsLoad(logic [3:0] op);
        return !op[3];
    endfunction

    // log2 of access size in bytes
    function automatic logic [1:0] opSize(logic [3:0] op);
        case (op)
            OP_LD, OP_STD:          return 2'd3;
            OP_LWZ, OP_LWA, OP_STW: return 2'd2;
            OP_LHZ, OP_LHA, OP_STH: return 2'd1;
            default:                return 2'd0;
        endcase
    endfunction

    function automatic logic opSigned(logic [3:0] op);
        return (op == OP_LWA) || (op == OP_LHA);
    endfunction

    function automatic logic [2:0] alignMask(logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Right-align a field held in the top bits of a doubleword and extend it.
    function automatic logic [DATA_W-1:0] extend(logic [DATA_W-1:0] top, logic [1:0] size, logic sgn);
        logic [5:0] sh;
        case (size)
            2'd0:    sh = 6'd56;
            2'd1:    sh = 6'd48;
            2'd2:    sh = 6'd32;
            default: sh = 6'd0;
        endcase
        if (sgn) return DATA_W'($signed(top) >>> sh);
        return top >> sh;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling: load extraction/extension and store lane merge.
module lsu_lane_align
    import upower_lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [3:0]        op,
    input  logic [2:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] loadData_c,
    output logic [DATA_W-1:0] mergeData_c
);

    logic [1:0]        size;
    logic [5:0]        laneShift;
    logic [DATA_W-1:0] fieldTop;
    logic [DATA_W-1:0] maskTop;
    logic [DATA_W-1:0] dataTop;
    logic [DATA_W-1:0] laneMask;

    always_comb begin
        size       = opSize(op);
        laneShift  = {offset, 3'b000};
        fieldTop   = word << laneShift;
        loadData_c = extend(fieldTop, size, opSigned(op));

        // Store data is left-aligned first, then slid down to its byte offset
        case (size)
            2'd0: begin
                maskTop = {8'hFF, 56'h0};
                dataTop = {wdata[7:0], 56'h0};
            end
            2'd1: begin
                maskTop = {16'hFFFF, 48'h0};
                dataTop = {wdata[15:0], 48'h0};
            end
            2'd2: begin
                maskTop = {32'hFFFF_FFFF, 32'h0};
                dataTop = {wdata[31:0], 32'h0};
            end
            default: begin
                maskTop = {DATA_W{1'b1}};
                dataTop = wdata;
            end
        endcase
        laneMask    = maskTop >> laneShift;
        mergeData_c = (word & ~laneMask) | ((dataTop >> laneShift) & laneMask);
    end

endmodule

// File: rtl/load_store_unit.sv
// uPOWER load/store unit: EA generation, range/alignment check, memory
// sequencing (read, write, read-modify-write) and one-cycle response.
module load_store_unit
    import upower_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_base,
    input  logic [15:0]       req_disp,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    lsu_state_e        state;
    logic [3:0]        opQ;
    logic [2:0]        offsetQ;
    logic [DATA_W-1:0] wdataQ;

    logic [DATA_W-1:0] ea_c;
    logic [IDX_W-1:0]  index_c;
    logic              misaligned_c;
    logic              outOfRange_c;
    logic              reqErr_c;
    logic              accept_c;
    logic [DATA_W-1:0] loadData_c;
    logic [DATA_W-1:0] mergeData_c;

    // Request decode on the incoming (not yet registered) request
    always_comb begin
        ea_c         = req_base + {{48{req_disp[15]}}, req_disp};
        index_c      = ea_c[3+IDX_W-1:3];
        misaligned_c = (ea_c[2:0] & alignMask(opSize(req_op))) != 3'b000;
        outOfRange_c = ea_c[DATA_W-1:3] >= 61'(MEM_WORDS);
        reqErr_c     = !opLegal(req_op) || misaligned_c || outOfRange_c;
        accept_c     = req_valid && req_ready;
    end

    lsu_lane_align u_lane_align (
        .word        (mem_read_data),
        .op          (opQ),
        .offset      (offsetQ),
        .wdata       (wdataQ),
        .loadData_c  (loadData_c),
        .mergeData_c (mergeData_c)
    );

    // FSM with registered memory and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            mem_read       <= 1'b0;
            mem_read_addr  <= '0;
            mem_write      <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            opQ            <= '0;
            offsetQ        <= '0;
            wdataQ         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        req_ready <= 1'b0;
                        opQ       <= req_op;
                        offsetQ   <= ea_c[2:0];
                        wdataQ    <= req_wdata;
                        if (reqErr_c) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_op == OP_STD) begin
                            state          <= WR;
                            mem_write      <= 1'b1;
                            mem_write_addr <= DATA_W'(index_c);
                            mem_write_data <= req_wdata;
                        end else begin
                            state         <= RD;
                            mem_read      <= 1'b1;
                            mem_read_addr <= DATA_W'(index_c);
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    if (opIsLoad(opQ)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= loadData_c;
                    end else begin
                        // partial store: write back the merged doubleword
                        state          <= WR;
                        mem_write      <= 1'b1;
                        mem_write_addr <= mem_read_addr;
                        mem_write_data <= mergeData_c;
                    end
                end
                WR: begin
                    mem_write <= 1'b0;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
